signed_multiplier: RTL and testbench
====================================

Name: signed_multiplier

Overview:
- Sequential two's-complement signed multiplier: takes two WIDTH-bit signed operands and produces the full 2*WIDTH-bit signed product.
- Uses an iterative shift-add datapath on operand magnitudes, with sign correction at the end.
- A valid/ready input handshake and a one-cycle output-valid pulse let it sit between the fixed-point MAC stages of the classifier datapath.

Parameters:
- WIDTH, 16, operand width in bits; legal range is 2 or more; the result is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b present this cycle
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  signed multiplicand
- b  input  WIDTH  signed multiplier
- out_valid  output  1  one-cycle pulse; result is valid
- result  output  2*WIDTH  signed product a*b, held until the next completion

Interface note: one clock; reset is asynchronous and active-low.

Behaviour:
- States are IDLE, CALC and DONE.
- Reset (rst_n=0, asynchronous):
  - state goes to IDLE, so in_ready=1;
  - out_valid=0, result=0, and all internal registers clear.
- IDLE, accept on a rising edge where in_valid && in_ready:
  - capture sign = a[W-1]^b[W-1];
  - capture |a| and |b| as WIDTH-bit unsigned values; -2^(W-1) maps to 2^(W-1) with no overflow;
  - clear the accumulator and the iteration counter, then go to CALC.
  - in_valid while not in IDLE is ignored; no buffering.
- CALC runs for WIDTH cycles. On each edge:
  - if the multiplier LSB is 1, accumulator += multiplicand (2*WIDTH-bit, multiplicand pre-zero-extended);
  - then multiplicand <<= 1 and multiplier >>= 1;
  - the counter increments; after the WIDTH-th iteration, go to DONE.
- Entering DONE, on the same edge as the last iteration:
  - result <= sign ? -(final accumulator) : (final accumulator), computed in 2*WIDTH bits;
  - out_valid = 1 for exactly the DONE cycle, and in_ready = 0 in DONE;
  - the next edge returns to IDLE.
- Latency: operands accepted at edge N means out_valid is high in the cycle after edge N+WIDTH. Throughput is one product per WIDTH+2 cycles.
- result keeps its value after out_valid drops, until the next DONE or reset.
- Arithmetic: the exact mathematical product, never saturated. The 2*WIDTH bits always suffice:
  - max magnitude is 2^(2W-2), from (-2^(W-1))^2;
  - for W=16: (-32768)*(-32768) = 1073741824 = 0x40000000, a positive value that fits.
- A zero operand still runs all WIDTH cycles, and result=0 with no negative-zero artefacts.
- Reset mid-CALC or in DONE aborts immediately: IDLE, result=0, no out_valid pulse.
- No combinational path from the inputs to any output; all outputs are registered or decoded from state.

Decomposition:
- Package mult_pkg holds:
  - the state enum type (IDLE, CALC, DONE);
  - a localparam for the counter width, $clog2(WIDTH+1), exported via a function taking WIDTH.
- One natural sub-module, mult_shift_add_core: the accumulator, shifting registers, counter and sign-correction datapath, driven by step/load strobes.
- The top-level signed_multiplier owns the FSM and the handshake.

Test Plan:
- Reset held low, then released → in_ready=1, out_valid=0, result=0. With a=100, b=3 → out_valid pulses WIDTH+1 cycles after the accept edge, result=300.
- a=200, b=-4 → result=-800. Then a=-25, b=-10 → result=250. Then a=0, b=1234 → result=0. Check that result holds between pulses.
- a=16'sh7FFF, b=16'sh7FFF → result=1073676289. Then a=-32768, b=-32768 → result=1073741824 (0x40000000). Then a=-32768, b=1 → result=-32768.
- Drive in_valid every cycle with changing operands → only operands present when in_ready=1 are taken. in_ready is low for the WIDTH+1 busy cycles, and one pulse appears per accepted pair.
- Assert rst_n=0 asynchronously mid-CALC (between clock edges) → outputs clear immediately and no out_valid pulse follows. A new operation after release computes correctly.
- Randomised signed pairs, including 0, ±1, -2^(W-1) and 2^(W-1)-1, checked against a*b. Repeat with WIDTH=8 (e.g. -128*-128=16384, 127*-128=-16256).

Source files
------------

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
//
// Purpose:
//   Shared types and helpers for the sequential signed multiplier.
//   Holds the controller state encoding and the sizing rule for the
//   iteration counter so the top level and the datapath core agree on it.
//
// Contents:
//   mult_state_t    - controller states (IDLE, CALC, DONE)
//   cnt_width()     - bits needed to count 0..width iterations
//   DEFAULT_WIDTH   - nominal operand width of the classifier datapath
//   DEFAULT_CNT_W   - counter width for DEFAULT_WIDTH
// ---------------------------------------------------------------------------
package mult_pkg;

    // Controller states. IDLE is the only state that accepts operands.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // The counter has to represent every value from 0 up to width, so it
    // needs $clog2(width+1) bits rather than $clog2(width).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/mult_shift_add_core.sv
// ---------------------------------------------------------------------------
// mult_shift_add_core
//
// Purpose:
//   Shift-add datapath of the signed multiplier. Works on operand
//   magnitudes and applies the sign once, when the last partial product
//   has been added.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset, clears every register
//   load    in   capture a/b: sign, magnitudes, clear accumulator/counter
//   step    in   perform one shift-add iteration
//   a       in   WIDTH-bit signed multiplicand
//   b       in   WIDTH-bit signed multiplier
//   last    out  high while the counter sits on the final iteration
//   result  out  2*WIDTH-bit signed product, held until the next update
// ---------------------------------------------------------------------------
module mult_shift_add_core
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic                 sign;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    // Magnitudes of the incoming operands, read as unsigned WIDTH-bit
    // values. The most negative input negates to itself in two's
    // complement, and that bit pattern read unsigned is exactly
    // 2^(WIDTH-1), so no extra bit is needed.
    always_comb begin
        a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
        b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    end

    // Accumulator value after the current iteration: add the shifted
    // multiplicand only when the multiplier bit being examined is set.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    assign last = (cnt == LAST_CNT);

    // Datapath registers. A load prepares a fresh product; each step
    // folds in one multiplier bit. On the final step the corrected
    // product is written straight into result from acc_next, so the
    // answer is ready the same edge the controller enters DONE.
    // Negating an all-zero accumulator gives zero, so a zero operand
    // never yields a stray negative value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (load) begin
            sign   <= a[WIDTH-1] ^ b[WIDTH-1];
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                result <= sign ? -acc_next : acc_next;
            end
        end
    end

endmodule

// File: rtl/signed_multiplier.sv
// ---------------------------------------------------------------------------
// signed_multiplier
//
// Purpose:
//   Sequential two's-complement multiplier producing the full 2*WIDTH-bit
//   product of two WIDTH-bit operands. Operands are taken with a
//   valid/ready handshake, the product is computed over WIDTH cycles by
//   the shift-add core, and completion is flagged with a one-cycle
//   out_valid pulse. One product every WIDTH+2 cycles at most.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands a/b present this cycle
//   in_ready   out  operands can be accepted (high only in IDLE)
//   a          in   WIDTH-bit signed multiplicand
//   b          in   WIDTH-bit signed multiplier
//   out_valid  out  one-cycle pulse, result is valid
//   result     out  2*WIDTH-bit signed product, held until next completion
// ---------------------------------------------------------------------------
module signed_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   result
);

    mult_state_t state;
    mult_state_t next_state;
    logic        load;
    logic        step;
    logic        last;

    // State register. Reset lands in IDLE so the block is immediately
    // ready; an abort mid-calculation simply drops the work in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath strobes. Operands are only looked at in
    // IDLE; in_valid in any other state is ignored, nothing is queued.
    // CALC steps the core every cycle and leaves after the iteration the
    // core flags as last. DONE lasts exactly one cycle.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Handshake outputs are decoded from the state register alone, so
    // there is no combinational path from any input to any output.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    mult_shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .a      (a),
        .b      (b),
        .last   (last),
        .result (result)
    );

endmodule

// File: tb/tb_signed_multiplier.sv
// ---------------------------------------------------------------------------
// tb_signed_multiplier
//
// Purpose:
//   Self-checking bench for signed_multiplier. A 16-bit and an 8-bit
//   instance share clock and reset; expected products come from plain
//   integer multiplication of the operands.
// ---------------------------------------------------------------------------
module tb_signed_multiplier;

    logic        clk;
    logic        rst_n;

    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        out_valid16;
    logic [31:0] result16;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        out_valid8;
    logic [15:0] result8;

    int tests;
    int failures;

    signed_multiplier #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .out_valid (out_valid16),
        .result    (result16)
    );

    signed_multiplier #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .result    (result8)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a stuck design can never hang the run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", tag, observed, expected);
        end
    endtask

    // Random operand with a bias towards the interesting corners.
    function automatic longint pickOperand(input int w);
        longint mn;
        longint mx;
        mn = -(longint'(1) << (w - 1));
        mx = (longint'(1) << (w - 1)) - 1;
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return 1;
            2:       return -1;
            3:       return mn;
            4:       return mx;
            default: return mn + longint'($urandom_range(0, (1 << w) - 1));
        endcase
    endfunction

    // One complete transaction: wait for ready, present operands for one
    // edge, then check latency, product, pulse width and result hold.
    task automatic applyStimulus(input bit use8, input longint x, input longint y,
                                 input string tag);
        int          w;
        int          cycles;
        int          waited;
        logic [63:0] mask;
        logic [63:0] expected;
        logic        rdy;
        logic        ov;
        logic [63:0] res;

        w        = use8 ? 8 : 16;
        mask     = (64'd1 << (2 * w)) - 64'd1;
        expected = 64'(x * y) & mask;

        @(negedge clk);
        waited = 0;
        rdy    = use8 ? in_ready8 : in_ready16;
        while (!rdy && waited < 40) begin
            @(negedge clk);
            waited++;
            rdy = use8 ? in_ready8 : in_ready16;
        end
        checkOutput({tag, "_ready"}, 64'(rdy), 64'd1);

        if (use8) begin
            a8 = x[7:0];
            b8 = y[7:0];
            in_valid8 = 1'b1;
        end else begin
            a16 = x[15:0];
            b16 = y[15:0];
            in_valid16 = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid8  = 1'b0;
        in_valid16 = 1'b0;

        cycles = 0;
        ov     = 1'b0;
        while (!ov && cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            ov = use8 ? out_valid8 : out_valid16;
        end
        res = use8 ? 64'(result8) : 64'(result16);
        checkOutput({tag, "_latency"}, 64'(cycles), 64'(w));
        checkOutput({tag, "_result"}, res, expected);

        @(negedge clk);
        ov  = use8 ? out_valid8 : out_valid16;
        res = use8 ? 64'(result8) : 64'(result16);
        checkOutput({tag, "_pulse"}, 64'(ov), 64'd0);
        checkOutput({tag, "_hold"}, res, expected);
    endtask

    // in_valid held high with new operands every cycle: only pairs seen
    // while ready are taken, each yields one pulse, busy spans WIDTH+1.
    task automatic streamTest();
        longint q[$];
        int     accepted;
        int     pulses;
        int     streak;
        longint x;
        longint y;
        accepted = 0;
        pulses   = 0;
        streak   = 0;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            if (out_valid16) begin
                pulses++;
                if (q.size() > 0) begin
                    checkOutput("stream_result", 64'(result16), 64'(q.pop_front()) & 64'hFFFF_FFFF);
                end else begin
                    checkOutput("stream_extra_pulse", 64'(pulses), 64'(accepted));
                end
            end
            if (in_ready16) begin
                if (streak > 0) begin
                    checkOutput("stream_busy_len", 64'(streak), 64'd17);
                end
                streak = 0;
            end else begin
                streak++;
            end
            x = pickOperand(16);
            y = pickOperand(16);
            a16 = x[15:0];
            b16 = y[15:0];
            in_valid16 = 1'b1;
            if (in_ready16) begin
                q.push_back(x * y);
                accepted++;
            end
        end
        @(negedge clk);
        in_valid16 = 1'b0;
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            if (out_valid16) begin
                pulses++;
                checkOutput("stream_result", 64'(result16), 64'(q.pop_front()) & 64'hFFFF_FFFF);
            end
            @(negedge clk);
        end
        checkOutput("stream_pulse_count", 64'(pulses), 64'(accepted));
    endtask

    initial begin
        int pulses;
        tests      = 0;
        failures   = 0;
        rst_n      = 1'b0;
        in_valid16 = 1'b0;
        in_valid8  = 1'b0;
        a16        = '0;
        b16        = '0;
        a8         = '0;
        b8         = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_ready16", 64'(in_ready16), 64'd1);
        checkOutput("rst_valid16", 64'(out_valid16), 64'd0);
        checkOutput("rst_result16", 64'(result16), 64'd0);
        checkOutput("rst_ready8", 64'(in_ready8), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready16", 64'(in_ready16), 64'd1);
        checkOutput("post_rst_result16", 64'(result16), 64'd0);

        applyStimulus(1'b0, 100, 3, "d100x3");
        applyStimulus(1'b0, 200, -4, "d200xm4");
        applyStimulus(1'b0, -25, -10, "dm25xm10");
        applyStimulus(1'b0, 0, 1234, "d0x1234");
        applyStimulus(1'b0, 32767, 32767, "dmaxmax");
        applyStimulus(1'b0, -32768, -32768, "dminmin");
        applyStimulus(1'b0, -32768, 1, "dminx1");

        streamTest();

        // Asynchronous reset between edges while the core is mid-product.
        applyStimulus(1'b0, 7, 9, "dpre_abort");
        @(negedge clk);
        a16 = 16'd1234;
        b16 = 16'hFFFB;
        in_valid16 = 1'b1;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ready", 64'(in_ready16), 64'd1);
        checkOutput("abort_valid", 64'(out_valid16), 64'd0);
        checkOutput("abort_result", 64'(result16), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (out_valid16) pulses++;
        end
        checkOutput("abort_no_pulse", 64'(pulses), 64'd0);
        applyStimulus(1'b0, -300, 77, "dpost_abort");

        // 8-bit instance corners.
        applyStimulus(1'b1, -128, -128, "e_minmin");
        applyStimulus(1'b1, 127, -128, "e_maxmin");
        applyStimulus(1'b1, -1, 1, "e_m1x1");

        for (int i = 0; i < 25; i++) begin
            applyStimulus(1'b0, pickOperand(16), pickOperand(16), "rand16");
        end
        for (int i = 0; i < 25; i++) begin
            applyStimulus(1'b1, pickOperand(8), pickOperand(8), "rand8");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
